// File: rtl/cnn_pkg.sv
// Shared CNN accelerator types and widths: layer configuration, scheduler states
// and the small helpers used to derive per-layer geometry without a multiplier.
package cnn_pkg;

  localparam int ADDR_W = 10;
  localparam int IW_W   = 5;
  localparam int KW_W   = 2;
  localparam int ST_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [IW_W-1:0] input_width;
    logic [KW_W-1:0] kernal_width;
    logic [ST_W-1:0] stride;
  } layer_cfg_t;

  function automatic logic cfg_valid(input layer_cfg_t cfg);
    return (cfg.kernal_width != '0) && (cfg.stride != '0) &&
           (IW_W'(cfg.kernal_width) <= cfg.input_width);
  endfunction

  // Output width floor((W-K)/S)+1; the stride is 1..3 so the divide stays tiny.
  function automatic logic [IW_W-1:0] calc_ow(input layer_cfg_t cfg);
    logic [IW_W-1:0] diff;
    logic [IW_W-1:0] quo;
    diff = cfg.input_width - IW_W'(cfg.kernal_width);
    case (cfg.stride)
      2'd2:    quo = diff >> 1;
      2'd3:    quo = diff / 5'd3;
      default: quo = diff;
    endcase
    return quo + 5'd1;
  endfunction

  // S*W via shift-and-add, used to step the window origin down one output row.
  function automatic logic [ADDR_W-1:0] stride_rows(input layer_cfg_t cfg);
    logic [ADDR_W-1:0] w;
    logic [ADDR_W-1:0] res;
    w = ADDR_W'(cfg.input_width);
    case (cfg.stride)
      2'd2:    res = w << 1;
      2'd3:    res = w + (w << 1);
      default: res = w;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Tap read channel from the window scheduler to the feature-map buffer / MAC array.
interface conv_window_scheduler_if;
  import cnn_pkg::*;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              first_tap;
  logic              last_tap;

  modport master (output rd_valid, rd_addr, first_tap, last_tap, input rd_ready);
  modport slave  (input rd_valid, rd_addr, first_tap, last_tap, output rd_ready);

endinterface

// File: rtl/conv_window_scheduler.sv
// Walks every output pixel and kernel tap of one conv/pool layer and issues buffer
// read addresses. Optional stall counter: define CONV_SCHED_STALL_CNT_EN.
module conv_window_scheduler
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IW_W-1:0]         input_width,
  input  logic [KW_W-1:0]         kernal_width,
  input  logic [ST_W-1:0]         stride,
  conv_window_scheduler_if.master rd,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
`ifdef CONV_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  state_t            state_q, state_d;
  layer_cfg_t        cfg_q, cfg_d, cfg_in;
  logic [IW_W-1:0]   ow_q, ow_d;
  logic [ADDR_W-1:0] sw_q, sw_d;

  logic [KW_W-1:0]   kx_q, kx_d, ky_q, ky_d;
  logic [IW_W-1:0]   ox_q, ox_d, oy_q, oy_d;

  // Address = window origin + kernel row offset + kx, all maintained by addition.
  logic [ADDR_W-1:0] oy_base_q, oy_base_d;
  logic [ADDR_W-1:0] win_base_q, win_base_d;
  logic [ADDR_W-1:0] row_off_q, row_off_d;

  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;

  logic              accept;
  logic              handshake;
  logic              final_tap;
  logic [KW_W-1:0]   k_last;
  logic [IW_W-1:0]   ow_last;

  assign cfg_in    = '{input_width: input_width, kernal_width: kernal_width, stride: stride};
  assign accept    = (state_q == IDLE) && start && cfg_valid(cfg_in);
  assign handshake = rd_valid_q && rd.rd_ready;
  assign k_last    = cfg_q.kernal_width - 2'd1;
  assign ow_last   = ow_q - 5'd1;
  assign final_tap = (kx_q == k_last) && (ky_q == k_last) &&
                     (ox_q == ow_last) && (oy_q == ow_last);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cfg_d      = cfg_q;
    ow_d       = ow_q;
    sw_d       = sw_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    oy_base_d  = oy_base_q;
    win_base_d = win_base_q;
    row_off_d  = row_off_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    first_d    = first_q;
    last_d     = last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = RUN;
          cfg_d      = cfg_in;
          ow_d       = calc_ow(cfg_in);
          sw_d       = stride_rows(cfg_in);
          kx_d       = '0;
          ky_d       = '0;
          ox_d       = '0;
          oy_d       = '0;
          oy_base_d  = '0;
          win_base_d = '0;
          row_off_d  = '0;
          rd_valid_d = 1'b1;
          rd_addr_d  = '0;
          first_d    = 1'b1;
          last_d     = (kernal_width == 2'd1);
          busy_d     = 1'b1;
        end else if (start) begin
          cfg_err_d = 1'b1;
        end
      end

      RUN: begin
        if (handshake) begin
          if (final_tap) begin
            state_d    = DONE;
            rd_valid_d = 1'b0;
            rd_addr_d  = '0;
            first_d    = 1'b0;
            last_d     = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            if (kx_q != k_last) begin
              kx_d = kx_q + 2'd1;
            end else begin
              kx_d = '0;
              if (ky_q != k_last) begin
                ky_d      = ky_q + 2'd1;
                row_off_d = row_off_q + ADDR_W'(cfg_q.input_width);
              end else begin
                ky_d      = '0;
                row_off_d = '0;
                if (ox_q != ow_last) begin
                  ox_d       = ox_q + 5'd1;
                  win_base_d = win_base_q + ADDR_W'(cfg_q.stride);
                end else begin
                  ox_d       = '0;
                  oy_d       = oy_q + 5'd1;
                  oy_base_d  = oy_base_q + sw_q;
                  win_base_d = oy_base_q + sw_q;
                end
              end
            end
            rd_addr_d = win_base_d + row_off_d + ADDR_W'(kx_d);
            first_d   = (kx_d == '0) && (ky_d == '0);
            last_d    = (kx_d == k_last) && (ky_d == k_last);
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      ow_q       <= '0;
      sw_q       <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      oy_base_q  <= '0;
      win_base_q <= '0;
      row_off_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      ow_q       <= ow_d;
      sw_q       <= sw_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      oy_base_q  <= oy_base_d;
      win_base_q <= win_base_d;
      row_off_q  <= row_off_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      first_q    <= first_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign rd.rd_valid  = rd_valid_q;
  assign rd.rd_addr   = rd_addr_q;
  assign rd.first_tap = first_q;
  assign rd.last_tap  = last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;

`ifdef CONV_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  // Back-pressure seen by this layer; value survives DONE/IDLE for readout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && rd_valid_q && !rd.rd_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench for conv_window_scheduler: expected taps are queued at start
// and popped on each observed handshake.
module tb_conv_window_scheduler;
  import cnn_pkg::*;

  typedef struct {
    int addr;
    bit first;
    bit last;
  } tap_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic [IW_W-1:0]   input_width;
  logic [KW_W-1:0]   kernal_width;
  logic [ST_W-1:0]   stride;
  logic              busy;
  logic              done;
  logic              cfg_err;
`ifdef CONV_SCHED_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  conv_window_scheduler_if rd ();

  conv_window_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .input_width  (input_width),
    .kernal_width (kernal_width),
    .stride       (stride),
    .rd           (rd),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
`ifdef CONV_SCHED_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  int   n_checks = 0;
  int   n_errors = 0;
  tap_t exp_q[$];
  int   cyc = 0;
  bit   ready_toggle = 0;
  bit   done_exp = 0;
  bit   cfg_err_exp = 0;
  int   tap_cnt = 0;
  int   last_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   stall_exp = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    rd.rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rd.rd_ready = ready_toggle ? ~rd.rd_ready : 1'b1;
    end
  end

  // Monitor: compare presented tap against the scoreboard head every cycle.
  initial forever begin
    @(negedge clk);
    check("done", done, done_exp);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    done_exp = 0;
    check("cfg_err", cfg_err, cfg_err_exp);
    if (exp_q.size() > 0) begin
      check("rd_valid", rd.rd_valid, 1);
      check("busy", busy, 1);
      check("rd_addr", rd.rd_addr, exp_q[0].addr);
      check("first_tap", rd.first_tap, exp_q[0].first);
      check("last_tap", rd.last_tap, exp_q[0].last);
      if (rd.rd_ready) begin
        if (exp_q[0].last) last_cnt++;
        void'(exp_q.pop_front());
        tap_cnt++;
        if (exp_q.size() == 0) done_exp = 1;
      end else begin
        stall_exp++;
      end
    end else begin
      check("idle_rd_valid", rd.rd_valid, 0);
      check("idle_busy", busy, 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int a_cyc, n_taps, ow_exp, tap_base, last_base, done_base, stall_base;

  // Drives start; on a legal config pushes every expected tap once the accept edge passes.
  task automatic start_layer(input int w, input int k, input int s, input bit hold,
                             output bit accepted);
    tap_t t;
    accepted = (k >= 1) && (s >= 1) && (k <= w);
    @(posedge clk);
    #1;
    input_width  = IW_W'(w);
    kernal_width = KW_W'(k);
    stride       = ST_W'(s);
    start        = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    input_width  = '0;
    kernal_width = '0;
    stride       = '0;
    a_cyc      = cyc;
    tap_base   = tap_cnt;
    last_base  = last_cnt;
    done_base  = done_cnt;
    stall_base = stall_exp;
    if (accepted) begin
      ow_exp = (w - k) / s + 1;
      n_taps = ow_exp * ow_exp * k * k;
      for (int oy = 0; oy < ow_exp; oy++)
        for (int ox = 0; ox < ow_exp; ox++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              t.addr  = (oy * s + ky) * w + ox * s + kx;
              t.first = (ky == 0) && (kx == 0);
              t.last  = (ky == k - 1) && (kx == k - 1);
              exp_q.push_back(t);
            end
    end else begin
      cfg_err_exp = 1;
      @(posedge clk);
      #1;
      cfg_err_exp = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rejected_no_taps", tap_cnt - tap_base, 0);
    end
  endtask

  task automatic run_layer(input int w, input int k, input int s, input bit toggle, input bit hold);
    bit acc;
    bit seen;
    ready_toggle = toggle;
    start_layer(w, k, s, hold, acc);
    seen = 0;
    for (int i = 0; i < 3 * n_taps + 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != done_base) seen = 1;
    end
    start = 1'b0;
    ready_toggle = 0;
    check("done_seen", seen, 1);
    if (!seen) exp_q.delete();
    check("tap_total", tap_cnt - tap_base, n_taps);
    check("last_tap_pulses", last_cnt - last_base, ow_exp * ow_exp);
    if (!toggle) check("done_cycle", done_cyc, a_cyc + n_taps);
`ifdef CONV_SCHED_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall_exp - stall_base);
`endif
    repeat (4) @(posedge clk);
    #1;
    check("single_done", done_cnt - done_base, 1);
  endtask

  bit acc_r;
  bit hit;

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    input_width  = '0;
    kernal_width = '0;
    stride       = '0;
    repeat (2) @(negedge clk);
    check("rst_rd_valid", rd.rd_valid, 0);
    check("rst_rd_addr", rd.rd_addr, 0);
    check("rst_first_tap", rd.first_tap, 0);
    check("rst_last_tap", rd.last_tap, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
`ifdef CONV_SCHED_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_layer(26, 2, 2, 0, 0);
    run_layer(5, 1, 1, 0, 0);
    run_layer(28, 3, 1, 1, 0);

    start_layer(2, 3, 1, 0, acc_r);
    start_layer(5, 2, 0, 0, acc_r);
    start_layer(7, 0, 1, 0, acc_r);

    // Reset in the middle of a layer.
    start_layer(13, 3, 1, 0, acc_r);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (tap_cnt - tap_base >= 100) hit = 1;
    end
    check("reached_tap_100", hit, 1);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_rd_valid", rd.rd_valid, 0);
    check("midrst_rd_addr", rd.rd_addr, 0);
    check("midrst_first_tap", rd.first_tap, 0);
    check("midrst_last_tap", rd.last_tap, 0);
    check("midrst_busy", busy, 0);
`ifdef CONV_SCHED_STALL_CNT_EN
    check("midrst_stall_cnt", stall_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - done_base, 0);
    run_layer(6, 2, 1, 0, 0);

    // Start held high for the whole run, then a fresh run.
    run_layer(9, 3, 2, 0, 1);
    run_layer(10, 3, 3, 1, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
